// File: rtl/decode_writeback.sv
`default_nettype none
// ============================================================================
// Module      : decode_writeback
// Description : Y86-64 SEQ decode and write-back stage with a 15 x 64-bit
//               register file.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_writeback #(
    parameter int DATA_W = 64,
    parameter int NREG   = 15,
    parameter int RSP_ID = 4,
    parameter int RNONE  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              wb_en,
    output logic [3:0]        srcA,
    output logic [3:0]        srcB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB
);

    localparam logic [3:0] c_IRRMOVQ = 4'h2;
    localparam logic [3:0] c_IIRMOVQ = 4'h3;
    localparam logic [3:0] c_IRMMOVQ = 4'h4;
    localparam logic [3:0] c_IMRMOVQ = 4'h5;
    localparam logic [3:0] c_IOPQ    = 4'h6;
    localparam logic [3:0] c_ICALL   = 4'h8;
    localparam logic [3:0] c_IRET    = 4'h9;
    localparam logic [3:0] c_IPUSHQ  = 4'hA;
    localparam logic [3:0] c_IPOPQ   = 4'hB;

    localparam logic [3:0] c_RSP   = 4'(RSP_ID);
    localparam logic [3:0] c_RNONE = 4'(RNONE);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [3:0]        w_src_a;
    logic [3:0]        w_src_b;
    logic [3:0]        w_dst_e;
    logic [3:0]        w_dst_m;
    logic [DATA_W-1:0] w_val_a;
    logic [DATA_W-1:0] w_val_b;

    always_comb begin
        w_src_a = c_RNONE;
        w_src_b = c_RNONE;
        w_dst_e = c_RNONE;
        w_dst_m = c_RNONE;
        case (icode)
            c_IRRMOVQ: begin
                w_src_a = rA;
                w_dst_e = cnd ? rB : c_RNONE;
            end
            c_IIRMOVQ: begin
                w_dst_e = rB;
            end
            c_IRMMOVQ: begin
                w_src_a = rA;
                w_src_b = rB;
            end
            c_IMRMOVQ: begin
                w_src_b = rB;
                w_dst_m = rA;
            end
            c_IOPQ: begin
                w_src_a = rA;
                w_src_b = rB;
                w_dst_e = rB;
            end
            c_ICALL: begin
                w_src_b = c_RSP;
                w_dst_e = c_RSP;
            end
            c_IRET: begin
                w_src_a = c_RSP;
                w_src_b = c_RSP;
                w_dst_e = c_RSP;
            end
            c_IPUSHQ: begin
                w_src_a = rA;
                w_src_b = c_RSP;
                w_dst_e = c_RSP;
            end
            c_IPOPQ: begin
                w_src_a = c_RSP;
                w_src_b = c_RSP;
                w_dst_e = c_RSP;
                w_dst_m = rA;
            end
            default: begin
                w_src_a = c_RNONE;
            end
        endcase
    end

    // Read by match so any ID outside the file (including RNONE) yields zero.
    always_comb begin
        w_val_a = '0;
        w_val_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (w_src_a == 4'(i)) w_val_a = r_regs[i];
            if (w_src_b == 4'(i)) w_val_b = r_regs[i];
        end
    end

    // The M port has priority so popq %rsp leaves the popped value in %rsp.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (wb_en) begin
            for (int i = 0; i < NREG; i++) begin
                if (w_dst_m == 4'(i) && w_dst_m != c_RNONE)
                    r_regs[i] <= valM;
                else if (w_dst_e == 4'(i) && w_dst_e != c_RNONE)
                    r_regs[i] <= valE;
            end
        end
    end

    assign srcA = w_src_a;
    assign srcB = w_src_b;
    assign dstE = w_dst_e;
    assign dstM = w_dst_m;
    assign valA = w_val_a;
    assign valB = w_val_b;

endmodule
`default_nettype wire

// File: tb/tb_decode_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_writeback
// Description : Scoreboard bench for decode_writeback against a register-file
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_writeback;

    localparam logic [3:0] c_RSP   = 4'd4;
    localparam logic [3:0] c_RNONE = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode, rA, rB;
    logic        cnd;
    logic [63:0] valE, valM;
    logic        wb_en;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB;

    always #5 clk = ~clk;

    decode_writeback #(
        .DATA_W(64), .NREG(15), .RSP_ID(4), .RNONE(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .valE(valE), .valM(valM), .wb_en(wb_en),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .valA(valA), .valB(valB)
    );

    typedef struct {
        logic [3:0]  sa, sb, de, dm;
        logic [63:0] va, vb;
    } exp_t;

    exp_t        scb[$];
    logic [63:0] ref_regs [15];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rd(input logic [3:0] id);
        return (id < 4'd15) ? ref_regs[id] : 64'd0;
    endfunction

    // Register usage per instruction class, straight from the ISA tables.
    function automatic exp_t predict(input logic [3:0] ic, ra, rb, input logic c);
        exp_t e;
        e.sa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra :
               (ic inside {4'h9, 4'hB}) ? c_RSP : c_RNONE;
        e.sb = (ic inside {4'h4, 4'h5, 4'h6}) ? rb :
               (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? c_RSP : c_RNONE;
        e.de = (ic inside {4'h3, 4'h6} || (ic == 4'h2 && c)) ? rb :
               (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? c_RSP : c_RNONE;
        e.dm = (ic inside {4'h5, 4'hB}) ? ra : c_RNONE;
        e.va = rd(e.sa);
        e.vb = rd(e.sb);
        return e;
    endfunction

    // Drive one instruction, queue its expectation, then commit it at the edge.
    task automatic step(input logic [3:0] ic, ra, rb, input logic c,
                        input logic [63:0] ve, vm, input logic we, rn, input bit chk);
        exp_t e;
        icode = ic; rA = ra; rB = rb; cnd = c;
        valE = ve; valM = vm; wb_en = we; rst_n = rn;
        e = predict(ic, ra, rb, c);
        if (chk) scb.push_back(e);
        @(posedge clk);
        if (!rn) begin
            foreach (ref_regs[i]) ref_regs[i] = 64'd0;
        end else if (we) begin
            if (e.de != c_RNONE) ref_regs[e.de] = ve;
            if (e.dm != c_RNONE) ref_regs[e.dm] = vm;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (scb.size() > 0) begin
            exp_t e;
            e = scb.pop_front();
            check("srcA", {60'd0, srcA}, {60'd0, e.sa});
            check("srcB", {60'd0, srcB}, {60'd0, e.sb});
            check("dstE", {60'd0, dstE}, {60'd0, e.de});
            check("dstM", {60'd0, dstM}, {60'd0, e.dm});
            check("valA", valA, e.va);
            check("valB", valB, e.vb);
        end
    end

    initial begin
        int wait_cyc;
        foreach (ref_regs[i]) ref_regs[i] = 64'd0;
        icode = 4'h1; rA = c_RNONE; rB = c_RNONE; cnd = 1'b0;
        valE = '0; valM = '0; wb_en = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;

        // Reset clears every register
        step(4'h3, c_RNONE, 4'd5, 1'b0, 64'h55, 64'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++)
            step(4'h2, 4'(i), c_RNONE, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1);

        // irmovq then OPq reading it back
        step(4'h3, c_RNONE, 4'd2, 1'b0, 64'h1234, 64'h0, 1'b1, 1'b1, 1'b1);
        step(4'h6, 4'd0, 4'd2, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1);

        // cmov gated off, then on
        step(4'h2, 4'd1, 4'd3, 1'b0, 64'd5, 64'h0, 1'b1, 1'b1, 1'b1);
        step(4'h6, 4'd3, 4'd3, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1);
        step(4'h2, 4'd1, 4'd3, 1'b1, 64'd5, 64'h0, 1'b1, 1'b1, 1'b1);
        step(4'h6, 4'd3, 4'd3, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1);

        // popq %rsp: memory value wins
        step(4'hB, 4'd4, c_RNONE, 1'b0, 64'd8, 64'hAA, 1'b1, 1'b1, 1'b1);
        step(4'h9, c_RNONE, c_RNONE, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1);

        // Read during write returns the old value
        step(4'h3, c_RNONE, 4'd1, 1'b0, 64'd7, 64'h0, 1'b1, 1'b1, 1'b1);
        step(4'h6, 4'd1, 4'd1, 1'b0, 64'd9, 64'h0, 1'b1, 1'b1, 1'b1);
        step(4'h6, 4'd1, 4'd1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1);

        // wb_en gating and reset overriding a commit
        step(4'h3, c_RNONE, 4'd5, 1'b0, 64'd1, 64'h0, 1'b0, 1'b1, 1'b1);
        step(4'h6, 4'd5, 4'd5, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1);
        step(4'h3, c_RNONE, 4'd5, 1'b0, 64'h77, 64'h0, 1'b1, 1'b1, 1'b1);
        step(4'h3, c_RNONE, 4'd5, 1'b0, 64'd3, 64'h0, 1'b1, 1'b0, 1'b1);
        step(4'h6, 4'd5, 4'd2, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1);

        // Random instruction stream
        for (int n = 0; n < 600; n++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) != 0), 1'b1);
        end

        wait_cyc = 0;
        while (scb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        check("scoreboard_drained", 64'(scb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
